// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared defaults, request record and priority encoder for the writeback arbiter.
package regfile_arb_pkg;
  localparam int DEF_NREQ = 2;
  localparam int DEF_AW = 5;
  localparam int DEF_DW = 32;
  localparam int DEF_STARVE_MAX = 4;
  typedef struct packed {
    logic [DEF_AW-1:0] addr;
    logic [DEF_DW-1:0] data;
  } wb_req_t;
  function automatic logic [1:0] prio_idx(input logic [3:0] v);
    return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: valid/ready writeback request bus from NREQ requesters to the arbiter.
interface regfile_wb_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  modport master(output req_valid, req_addr, req_data, input req_ready);
  modport slave(input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: busy bit per register with set-wins-over-clear and read-hazard stall.
module regfile_scoreboard
  import regfile_arb_pkg::*;
#(
  parameter int AW = DEF_AW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sb_set_valid,
  input  logic [AW-1:0]    sb_set_addr,
  input  logic             clr_valid,
  input  logic [AW-1:0]    clr_addr,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  output logic [2**AW-1:0] busy,
  output logic             stall
);
  localparam int NR = 2**AW;
  logic [NR-1:0] r_busy;
  logic [NR-1:0] w_set;
  logic [NR-1:0] w_clr;
  assign w_set = sb_set_valid ? (NR'(1) << sb_set_addr) & ~NR'(1) : '0;
  assign w_clr = clr_valid ? NR'(1) << clr_addr : '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_busy <= '0;
    else r_busy <= (r_busy & ~w_clr) | w_set;
  assign busy = r_busy;
  // the we3 term covers the cycle before the registered write lands in the regfile
  assign stall = (ra1 != '0 && (r_busy[ra1] || (we3 && wa3 == ra1))) ||
                 (ra2 != '0 && (r_busy[ra2] || (we3 && wa3 == ra2)));
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: fixed-priority, starvation-aged sharing of the regfile write port.
// Define REGFILE_ARB_SCOREBOARD_EN to build the in-flight destination scoreboard.
module regfile_wb_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                 clk,
  input  logic                 reset_n,
  regfile_wb_arbiter_if.slave  bus,
  output logic                 we3,
  output logic [AW-1:0]        wa3,
  output logic [DW-1:0]        wd3,
  input  logic                 sb_set_valid,
  input  logic [AW-1:0]        sb_set_addr,
  input  logic [AW-1:0]        ra1,
  input  logic [AW-1:0]        ra2,
  output logic [2**AW-1:0]     busy,
  output logic                 stall
);
  logic [NREQ-1:0][3:0] r_wait;
  logic [3:0] w_valid;
  logic [3:0] w_starved;
  logic [1:0] w_idx;
  logic w_hs;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic r_we3;
  logic [AW-1:0] r_wa3;
  logic [DW-1:0] r_wd3;
  always_comb begin
    w_valid = 4'(bus.req_valid);
    w_starved = '0;
    for (int i = 0; i < NREQ; i++) w_starved[i] = bus.req_valid[i] && r_wait[i] == 4'(STARVE_MAX);
  end
  // starved requesters preempt the plain fixed-priority order
  assign w_idx = prio_idx(|w_starved ? w_starved : w_valid);
  assign bus.req_ready = |w_valid ? NREQ'(1) << w_idx : '0;
  assign w_hs = |w_valid;
  assign w_addr = bus.req_addr[w_idx*AW +: AW];
  assign w_data = bus.req_data[w_idx*DW +: DW];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_wait <= '0;
    else
      for (int i = 0; i < NREQ; i++)
        r_wait[i] <= !(bus.req_valid[i] && !bus.req_ready[i]) ? 4'd0 :
                     r_wait[i] == 4'(STARVE_MAX) ? r_wait[i] : r_wait[i] + 4'd1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_we3 <= 1'b0;
      r_wa3 <= '0;
      r_wd3 <= '0;
    end else if (w_hs) begin
      r_we3 <= w_addr != '0;
      r_wa3 <= w_addr;
      r_wd3 <= w_data;
    end else r_we3 <= 1'b0;
  assign we3 = r_we3;
  assign wa3 = r_wa3;
  assign wd3 = r_wd3;
`ifdef REGFILE_ARB_SCOREBOARD_EN
  regfile_scoreboard #(.AW(AW)) u_sb (
    .clk(clk),
    .reset_n(reset_n),
    .sb_set_valid(sb_set_valid),
    .sb_set_addr(sb_set_addr),
    .clr_valid(w_hs && w_addr != '0),
    .clr_addr(w_addr),
    .ra1(ra1),
    .ra2(ra2),
    .we3(r_we3),
    .wa3(r_wa3),
    .busy(busy),
    .stall(stall)
  );
`else
  logic w_unused;
  assign w_unused = ^{sb_set_valid, sb_set_addr};
  assign busy = '0;
  assign stall = (ra1 != '0 && r_we3 && r_wa3 == ra1) || (ra2 != '0 && r_we3 && r_wa3 == ra2);
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed plus randomized check against a behavioural arbiter/scoreboard model.
module tb_regfile_wb_arbiter;
  localparam int NREQ = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SM = 4;
`ifdef REGFILE_ARB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  regfile_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();
  logic we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;
  logic sb_set_valid;
  logic [AW-1:0] sb_set_addr;
  logic [AW-1:0] ra1;
  logic [AW-1:0] ra2;
  logic [31:0] busy;
  logic stall;
  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .we3(we3),
    .wa3(wa3),
    .wd3(wd3),
    .sb_set_valid(sb_set_valid),
    .sb_set_addr(sb_set_addr),
    .ra1(ra1),
    .ra2(ra2),
    .busy(busy),
    .stall(stall)
  );
  int checks = 0;
  int failures = 0;
  int wait_m[NREQ];
  bit we_m;
  logic [AW-1:0] wa_m;
  logic [DW-1:0] wd_m;
  bit busy_m[32];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [AW-1:0] addr_of(int i);
    return bus.req_addr[i*AW +: AW];
  endfunction
  function automatic int grant_m();
    for (int i = 0; i < NREQ; i++) if (bus.req_valid[i] && wait_m[i] == SM) return i;
    for (int i = 0; i < NREQ; i++) if (bus.req_valid[i]) return i;
    return -1;
  endfunction
  function automatic logic [31:0] busy_vec();
    logic [31:0] v = '0;
    for (int r = 0; r < 32; r++) v[r] = busy_m[r];
    return v;
  endfunction
  function automatic bit haz(logic [AW-1:0] ra);
    return ra != 0 && ((SB && busy_m[ra]) || (we_m && wa_m == ra));
  endfunction
  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) wait_m[i] = 0;
    for (int r = 0; r < 32; r++) busy_m[r] = 0;
    we_m = 0;
    wa_m = '0;
    wd_m = '0;
  endtask
  task automatic set_req(input int i, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i] = v;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask
  // one clock: compare at the falling edge, then advance the model across the rising edge
  task automatic cyc(output logic [NREQ-1:0] rdy);
    int g;
    logic [NREQ-1:0] oh;
    @(negedge clk);
    g = grant_m();
    oh = g < 0 ? '0 : NREQ'(1) << g;
    rdy = bus.req_ready;
    check("ready", bus.req_ready, oh);
    check("we3", we3, we_m);
    check("wa3", wa3, wa_m);
    check("wd3", wd3, wd_m);
    check("busy", busy, busy_vec());
    check("stall", stall, haz(ra1) || haz(ra2));
    @(posedge clk);
    for (int i = 0; i < NREQ; i++)
      wait_m[i] = (bus.req_valid[i] && i != g) ? (wait_m[i] + 1 > SM ? SM : wait_m[i] + 1) : 0;
    if (g >= 0) begin
      we_m = addr_of(g) != 0;
      wa_m = addr_of(g);
      wd_m = bus.req_data[g*DW +: DW];
      if (SB && addr_of(g) != 0) busy_m[addr_of(g)] = 0;
    end else we_m = 0;
    if (SB && sb_set_valid && sb_set_addr != 0) busy_m[sb_set_addr] = 1;
    #1;
  endtask
  initial begin
    logic [NREQ-1:0] rdy;
    logic [NREQ-1:0] pend;
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    sb_set_valid = 0;
    sb_set_addr = '0;
    ra1 = '0;
    ra2 = '0;
    model_reset();
    #1;
    check("rst_we3", we3, 0);
    check("rst_wa3", wa3, 0);
    check("rst_wd3", wd3, 0);
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 0);
    bus.req_valid = 3'b110;
    #1;
    check("rst_ready", bus.req_ready, 3'b010);
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    set_req(0, 1, 5'd3, 32'hC0DEBABE);
    cyc(rdy);
    check("t1_ready", rdy, 3'b001);
    set_req(0, 0, 5'd3, 32'hC0DEBABE);
    check("t1_we3", we3, 1);
    check("t1_wa3", wa3, 3);
    check("t1_wd3", wd3, 32'hC0DEBABE);
    cyc(rdy);
    check("t1_we3_off", we3, 0);
    set_req(0, 1, 5'd1, 32'h11111111);
    set_req(1, 1, 5'd2, 32'h22222222);
    for (int k = 0; k < 10; k++) begin
      cyc(rdy);
      check("t2_grant", rdy, (k == 4 || k == 9) ? 3'b010 : 3'b001);
    end
    set_req(0, 0, 5'd0, '0);
    set_req(1, 0, 5'd0, '0);
    cyc(rdy);
    set_req(1, 1, 5'd0, 32'hBAADBEEF);
    cyc(rdy);
    set_req(1, 0, 5'd0, '0);
    check("t3_ready", rdy, 3'b010);
    check("t3_we3", we3, 0);
    check("t3_busy", busy, 0);
    sb_set_valid = 1;
    sb_set_addr = 5'd5;
    ra1 = 5'd5;
    cyc(rdy);
    sb_set_valid = 0;
    check("t4_busy5", busy[5], SB);
    check("t4_stall_set", stall, SB);
    set_req(2, 1, 5'd5, 32'h55555555);
    cyc(rdy);
    set_req(2, 0, 5'd5, '0);
    check("t4_busy5_clr", busy[5], 0);
    check("t4_stall_inflight", stall, 1);
    cyc(rdy);
    check("t4_stall_done", stall, 0);
    sb_set_valid = 1;
    sb_set_addr = 5'd7;
    set_req(0, 1, 5'd7, 32'h77777777);
    cyc(rdy);
    sb_set_valid = 0;
    set_req(0, 0, 5'd7, '0);
    check("t4_set_wins", busy[7], SB);
    sb_set_valid = 1;
    sb_set_addr = 5'd9;
    cyc(rdy);
    sb_set_valid = 0;
    check("t6_busy9", busy[9], SB);
    cyc(rdy);
    set_req(0, 1, 5'd6, 32'h66666666);
    cyc(rdy);
    set_req(0, 0, 5'd6, '0);
    reset_n = 0;
    #1;
    check("t5_we3", we3, 0);
    check("t5_wa3", wa3, 0);
    check("t5_busy", busy, 0);
    model_reset();
    @(posedge clk);
    #1 reset_n = 1;
    pend = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend[i])
          set_req(i, $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom);
      sb_set_valid = $urandom_range(0, 3) == 0;
      sb_set_addr = 5'($urandom_range(0, 7));
      ra1 = 5'($urandom_range(0, 7));
      ra2 = 5'($urandom_range(0, 7));
      cyc(rdy);
      pend = bus.req_valid & ~rdy;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port (we3/wa3/wd3) between NREQ writeback requesters, such as the pipeline writeback stage, the multiply/divide unit and the load return path. Arbitration is fixed-priority with starvation aging. Each requester uses a valid/ready handshake, and the arbiter registers the winning write onto the port. An optional scoreboard tracks in-flight destination registers and raises a read-hazard stall for the regfile read ports ra1/ra2.

## Interface
- NREQ, 2: number of write requesters (2..4); index 0 is highest priority.
- AW, 5: register address width.
- DW, 32: register data width.
- STARVE_MAX, 4: cycles a requester may wait before it is promoted (1..15).

- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  requester i has a write pending.
- req_addr  in  NREQ*AW  destination register, requester i at bits [i*AW +: AW].
- req_data  in  NREQ*DW  write data, requester i at bits [i*DW +: DW].
- req_ready  out  NREQ  one-hot grant; a transfer occurs when valid&ready.
- we3  out  1  regfile write enable (registered).
- wa3  out  AW  regfile write address (registered).
- wd3  out  DW  regfile write data (registered).
- sb_set_valid  in  1  a long-latency op with destination sb_set_addr was issued this cycle.
- sb_set_addr  in  AW  destination register to mark busy.
- ra1, ra2  in  AW  current regfile read addresses.
- busy  out  2**AW  scoreboard vector; bit r set while register r has a write outstanding.
- stall  out  1  a read of ra1/ra2 would return stale data.

## Operation
- Grant is combinational from req_valid and the starvation state. At most one req_ready bit is high per cycle. The grant is never given to a requester whose valid is low.
- Priority order:
  - First, any requester whose wait counter equals STARVE_MAX, lowest index among them.
  - Otherwise, the lowest-index valid requester.
- Wait counter (one per requester, 4 bits):
  - Increments each cycle the requester has valid&!ready, saturating at STARVE_MAX.
  - Clears on handshake or when valid is low.
- Requesters must hold addr/data stable while valid&!ready. The arbiter does not check this.
- Writes to register 0:
  - The handshake completes normally.
  - we3 stays 0 for that transfer, so the write is discarded.
  - Such a write never affects busy.
- On handshake, the port register loads wa3=addr, wd3=data, and we3=(addr!=0). With no handshake, we3=0 and wa3/wd3 hold their previous values.
- Scoreboard:
  - sb_set_valid with a nonzero address sets busy[sb_set_addr].
  - An accepted write to address r clears busy[r].
  - If a set and a clear hit the same r in the same cycle, the set wins (a new op is in flight).
  - busy[0] is always 0.
- stall = (ra1!=0 & (busy[ra1] | (we3 & wa3==ra1))) | the same condition for ra2. The we3 term covers the cycle in which the registered write has not yet landed in the regfile.

## Timing
- Reset values: we3=0, wa3=0, wd3=0, busy=0, stall=0 (given ra1/ra2 inputs), all wait counters=0. req_ready follows req_valid combinationally even during reset.
- Latency:
  - Handshake at rising edge N; we3/wa3/wd3 are valid during cycle N+1.
  - The regfile captures the data at edge N+1.
  - A read issued in cycle N+2 returns the new value.
- Throughput: one write per cycle, sustained across requesters.
- Worst-case wait for requester i>0 under continuous higher-priority traffic is STARVE_MAX+1 cycles.
- Reset asserted mid-operation:
  - All outputs return to reset values immediately (asynchronously).
  - An in-flight port write is dropped and the scoreboard is cleared.
  - Requesters re-issue after reset deasserts.

## Configuration
- REGFILE_ARB_SCOREBOARD_EN defined: the scoreboard, busy and stall behave as described above.
- Not defined:
  - No scoreboard state is built and sb_set_valid/sb_set_addr are ignored.
  - busy is tied to 0.
  - stall reduces to the we3/wa3 in-flight term only.

## Structure
- Package regfile_arb_pkg holds:
  - Constants: default AW, DW, NREQ, STARVE_MAX.
  - Typedef wb_req_t {addr, data}.
  - Function for the lowest-set-index priority encode.
- Sub-module regfile_scoreboard contains the busy vector and the set/clear/hazard logic. It is instantiated only under REGFILE_ARB_SCOREBOARD_EN.

## Test plan
- Single write: req_valid=01 with addr=3 and data=C0DEBABE → req_ready=01; next cycle we3=1, wa3=3, wd3=C0DEBABE; the cycle after, we3=0.
- Contention: requesters 0 and 1 both valid continuously with STARVE_MAX=4 → requester 0 is granted for 4 cycles, requester 1 in the 5th cycle, and requester 1's counter is then 0.
- Register zero: requester 1 writes addr=0 data=BAADBEEF → handshake completes, we3 stays 0 the next cycle, busy unchanged.
- Scoreboard: sb_set r5, ra1=5 → stall=1; accepted write to r5 → busy[5]=0, stall stays 1 for the we3 cycle, then 0. Also check a same-cycle set and clear of r7 → busy[7]=1.
- Reset mid-write: assert reset_n=0 in the cycle after a handshake → we3=0 and busy=0 immediately, with no write to the regfile.
- Macro off: sb_set_valid on r9 → busy stays 0; stall follows only the we3/wa3 match.
